// File: rtl/pdm_pkg.sv
// Shared types and widths for the PDM-to-PCM decimator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pdm_pkg;

    localparam int SAMPLE_W = 8;
    localparam int ACC_W    = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    // A full window of ones at DECIM=256 counts to 256, one past the sample range.
    function automatic logic [SAMPLE_W-1:0] saturate(input logic [ACC_W-1:0] count);
        return (count > ACC_W'(255)) ? {SAMPLE_W{1'b1}} : count[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Circular sample buffer with pointer-based full/empty and synchronous flush.
// Latency: a push is visible at dout on the next edge when the buffer was empty.
// Backpressure: push while full without a pop is ignored; push+pop while full both succeed.
module sample_fifo
    import pdm_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Flush only rewinds pointers; stale contents keep dout stable while empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pdm_decimator.sv
// PDM microphone front end: mclk generation, box-car bit counting, settle discard, PCM FIFO.
// Latency: sample on dout one clk after its window closes (FIFO empty).
// Backpressure: dout_valid/dout_ready; samples arriving to a full FIFO are dropped and flagged.
module pdm_decimator
    import pdm_pkg::state_t, pdm_pkg::SAMPLE_W, pdm_pkg::ACC_W, pdm_pkg::saturate;
#(
    parameter int CLK_DIV    = 25,
    parameter int DECIM      = 256,
    parameter int SETTLE     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    output logic                mclk,
    input  logic                micData,
    output logic [SAMPLE_W-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                overflow
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DECIM);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [SET_W-1:0]    settle_cnt;
    logic                active;
    logic                tick;
    logic                bit_stb;
    logic                win_close;
    logic                settle_done;
    logic                push;
    logic                pop;
    logic                flush;
    logic                full;
    logic                empty;
    logic [SAMPLE_W-1:0] sample;

    // Dropping enable clears everything on the very next edge, not one cycle later.
    assign active      = (state != pdm_pkg::IDLE) && enable;
    assign tick        = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bit_stb     = tick && mclk;
    assign win_close   = bit_stb && (bit_cnt == BIT_W'(DECIM - 1));
    assign settle_done = (settle_cnt == SET_W'(SETTLE - 1));
    assign acc_sum     = acc + ACC_W'(micData);
    assign sample      = saturate(acc_sum);
    assign dout_valid  = !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= pdm_pkg::IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            pdm_pkg::IDLE: begin
                if (enable) begin
                    state_nxt = (SETTLE == 0) ? pdm_pkg::RUN : pdm_pkg::SETTLE;
                end
            end
            pdm_pkg::SETTLE: begin
                if (!enable) begin
                    state_nxt = pdm_pkg::IDLE;
                end else if (win_close && settle_done) begin
                    state_nxt = pdm_pkg::RUN;
                end
            end
            pdm_pkg::RUN: begin
                if (!enable) begin
                    state_nxt = pdm_pkg::IDLE;
                end
            end
            default: state_nxt = pdm_pkg::IDLE;
        endcase
    end

    always_comb begin
        push  = win_close && (state == pdm_pkg::RUN);
        pop   = dout_valid && dout_ready;
        flush = !active;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mclk       <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            acc        <= '0;
            settle_cnt <= '0;
            overflow   <= 1'b0;
        end else if (!active) begin
            mclk       <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            acc        <= '0;
            settle_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (tick) begin
                div_cnt <= '0;
                mclk    <= ~mclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            // The closing bit is folded into sample via acc_sum, so the next window starts clean.
            if (bit_stb) begin
                if (win_close) begin
                    acc     <= '0;
                    bit_cnt <= '0;
                end else begin
                    acc     <= acc_sum;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
            if (win_close && (state == pdm_pkg::SETTLE)) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .din   (sample),
        .pop   (pop),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

endmodule
